// File: rtl/b2_scfifo_ctrl.sv
// rtl/b2_scfifo_ctrl.sv - single-clock FIFO controller for an external registered-read RAM, normal or show-ahead mode
// Optional B2_SCFIFO_ERR_FLAGS_EN adds sticky ovf_o/unf_o request-error flags.
module b2_scfifo_ctrl #(
    parameter int AWIDTH             = 8,
    parameter int SHOWAHEAD          = 0,
    parameter int ALMOST_FULL_VALUE  = 2**AWIDTH-4,
    parameter int ALMOST_EMPTY_VALUE = 4
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              wrreq_i,
    input  logic              rdreq_i,
    output logic              wr_ena_o,
    output logic [AWIDTH-1:0] wr_addr_o,
    output logic              rd_ena_o,
    output logic [AWIDTH-1:0] rd_addr_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
`ifdef B2_SCFIFO_ERR_FLAGS_EN
    output logic              ovf_o,
    output logic              unf_o,
`endif
    output logic [AWIDTH:0]   usedw_o
);

    localparam logic [AWIDTH:0] DEPTH_W = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] ONE_W   = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [31:0]     AF_U    = ALMOST_FULL_VALUE;
    localparam logic [31:0]     AE_U    = ALMOST_EMPTY_VALUE;

    typedef enum logic [1:0] {EMPTY_ST, FETCH_ST, VALID_ST, FULL_ST} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AWIDTH-1:0] r_wr_addr;
    logic [AWIDTH-1:0] r_rd_addr;
    logic [AWIDTH:0]   r_usedw;
    logic [AWIDTH:0]   w_usedw_nxt;
    logic              r_empty;
    logic              r_full;
    logic              r_afull;
    logic              r_aempty;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_rd_ena;

    assign w_wr_acc = wrreq_i & ~r_full  & ~srst_i;
    assign w_rd_acc = rdreq_i & ~r_empty & ~srst_i;

    always_comb begin
        w_usedw_nxt = r_usedw;
        if (w_wr_acc && !w_rd_acc)
            w_usedw_nxt = r_usedw + ONE_W;
        else if (w_rd_acc && !w_wr_acc)
            w_usedw_nxt = r_usedw - ONE_W;

        w_state_nxt = r_state;
        w_rd_ena    = 1'b0;
        if (SHOWAHEAD != 0) begin
            // usedw counts the word already on q, so RAM holds usedw-1 unread words
            case (r_state)
                EMPTY_ST: if (w_wr_acc) w_state_nxt = FETCH_ST;
                FETCH_ST: begin
                    w_rd_ena    = 1'b1;
                    w_state_nxt = (w_usedw_nxt == DEPTH_W) ? FULL_ST : VALID_ST;
                end
                VALID_ST: begin
                    if (w_rd_acc) begin
                        if (r_usedw > ONE_W)
                            w_rd_ena = 1'b1;
                        else
                            w_state_nxt = w_wr_acc ? FETCH_ST : EMPTY_ST;
                    end else if (w_usedw_nxt == DEPTH_W) begin
                        w_state_nxt = FULL_ST;
                    end
                end
                FULL_ST: begin
                    if (w_rd_acc) begin
                        w_rd_ena    = 1'b1;
                        w_state_nxt = VALID_ST;
                    end
                end
            endcase
        end else begin
            w_rd_ena = w_rd_acc;
        end
        if (srst_i) begin
            w_rd_ena    = 1'b0;
            w_state_nxt = EMPTY_ST;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state   <= EMPTY_ST;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_usedw   <= '0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_afull   <= 1'b0;
            r_aempty  <= (ALMOST_EMPTY_VALUE > 0);
        end else begin
            r_state   <= w_state_nxt;
            r_usedw   <= w_usedw_nxt;
            r_full    <= (w_usedw_nxt == DEPTH_W);
            r_afull   <= (32'(w_usedw_nxt) >= AF_U);
            r_aempty  <= (32'(w_usedw_nxt) <  AE_U);
            r_empty   <= (SHOWAHEAD != 0) ? (w_state_nxt == EMPTY_ST || w_state_nxt == FETCH_ST)
                                          : (w_usedw_nxt == '0);
            if (w_wr_acc)
                r_wr_addr <= r_wr_addr + 1'b1;
            if (w_rd_ena)
                r_rd_addr <= r_rd_addr + 1'b1;
        end
    end

`ifdef B2_SCFIFO_ERR_FLAGS_EN
    logic r_ovf;
    logic r_unf;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (wrreq_i && r_full)
                r_ovf <= 1'b1;
            if (rdreq_i && r_empty)
                r_unf <= 1'b1;
        end
    end

    assign ovf_o = r_ovf;
    assign unf_o = r_unf;
`endif

    assign wr_ena_o       = w_wr_acc;
    assign wr_addr_o      = r_wr_addr;
    assign rd_ena_o       = w_rd_ena;
    assign rd_addr_o      = r_rd_addr;
    assign empty_o        = r_empty;
    assign full_o         = r_full;
    assign almost_full_o  = r_afull;
    assign almost_empty_o = r_aempty;
    assign usedw_o        = r_usedw;

endmodule

// File: tb/tb_b2_scfifo_ctrl.sv
// tb/tb_b2_scfifo_ctrl.sv - scoreboard bench for b2_scfifo_ctrl, normal and show-ahead instances with AWIDTH=3
module tb_b2_scfifo_ctrl;
    localparam int AW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic srst;
    logic n_wrreq, n_rdreq, s_wrreq, s_rdreq;
    logic n_wr_ena, n_rd_ena, n_empty, n_full, n_afull, n_aempty;
    logic s_wr_ena, s_rd_ena, s_empty, s_full, s_afull, s_aempty;
    logic [AW-1:0] n_wr_addr, n_rd_addr, s_wr_addr, s_rd_addr;
    logic [AW:0]   n_usedw, s_usedw;
`ifdef B2_SCFIFO_ERR_FLAGS_EN
    logic n_ovf, n_unf, s_ovf, s_unf;
`endif

    // external RAM models with registered read
    logic [7:0] n_mem [8];
    logic [7:0] s_mem [8];
    logic [7:0] n_q, s_q, n_wdata, s_wdata;
    always @(posedge clk) begin
        if (n_wr_ena) n_mem[n_wr_addr] <= n_wdata;
        if (n_rd_ena) n_q <= n_mem[n_rd_addr];
        if (s_wr_ena) s_mem[s_wr_addr] <= s_wdata;
        if (s_rd_ena) s_q <= s_mem[s_rd_addr];
    end

    b2_scfifo_ctrl #(.AWIDTH(AW), .SHOWAHEAD(0)) dut_n (
        .clk_i(clk), .srst_i(srst), .wrreq_i(n_wrreq), .rdreq_i(n_rdreq),
        .wr_ena_o(n_wr_ena), .wr_addr_o(n_wr_addr), .rd_ena_o(n_rd_ena), .rd_addr_o(n_rd_addr),
        .empty_o(n_empty), .full_o(n_full), .almost_full_o(n_afull), .almost_empty_o(n_aempty),
`ifdef B2_SCFIFO_ERR_FLAGS_EN
        .ovf_o(n_ovf), .unf_o(n_unf),
`endif
        .usedw_o(n_usedw));

    b2_scfifo_ctrl #(.AWIDTH(AW), .SHOWAHEAD(1)) dut_s (
        .clk_i(clk), .srst_i(srst), .wrreq_i(s_wrreq), .rdreq_i(s_rdreq),
        .wr_ena_o(s_wr_ena), .wr_addr_o(s_wr_addr), .rd_ena_o(s_rd_ena), .rd_addr_o(s_rd_addr),
        .empty_o(s_empty), .full_o(s_full), .almost_full_o(s_afull), .almost_empty_o(s_aempty),
`ifdef B2_SCFIFO_ERR_FLAGS_EN
        .ovf_o(s_ovf), .unf_o(s_unf),
`endif
        .usedw_o(s_usedw));

    int checks = 0;
    int failures = 0;
    logic [7:0] n_sb [$];
    logic [7:0] s_sb [$];
    logic [7:0] exp_d;
    logic [7:0] n_next = 8'h10;
    logic [7:0] s_next = 8'h80;
    logic [3:0] exp_used_n = '0;
    logic [2:0] exp_wa_n = '0, exp_ra_n = '0, exp_wa_s = '0, exp_ra_s = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        #1;
        checks++; if ({n_usedw, n_empty, n_full, n_afull, n_aempty, n_wr_ena, n_rd_ena, n_wr_addr, n_rd_addr} !== {4'd0, 6'b100100, 6'd0}) begin failures++; $display("FAIL reset_normal got=%h exp=%h", {n_usedw, n_empty, n_full, n_afull, n_aempty, n_wr_ena, n_rd_ena, n_wr_addr, n_rd_addr}, {4'd0, 6'b100100, 6'd0}); end
        checks++; if ({s_usedw, s_empty, s_full, s_afull, s_aempty, s_wr_ena, s_rd_ena, s_wr_addr, s_rd_addr} !== {4'd0, 6'b100100, 6'd0}) begin failures++; $display("FAIL reset_showahead got=%h exp=%h", {s_usedw, s_empty, s_full, s_afull, s_aempty, s_wr_ena, s_rd_ena, s_wr_addr, s_rd_addr}, {4'd0, 6'b100100, 6'd0}); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            n_wrreq = 1'b1; n_wdata = n_next; #1;
            checks++; if ({n_wr_ena, n_wr_addr} !== {1'b1, exp_wa_n}) begin failures++; $display("FAIL fill_wr got=%h exp=%h", {n_wr_ena, n_wr_addr}, {1'b1, exp_wa_n}); end
            n_sb.push_back(n_next); n_next++; exp_wa_n++; exp_used_n++;
            tick();
            checks++; if (n_usedw !== exp_used_n) begin failures++; $display("FAIL fill_usedw got=%0d exp=%0d", n_usedw, exp_used_n); end
            checks++; if ({n_empty, n_full, n_afull, n_aempty} !== {1'b0, (i == 7), (exp_used_n >= 4), (exp_used_n < 4)}) begin failures++; $display("FAIL fill_flags got=%b exp=%b", {n_empty, n_full, n_afull, n_aempty}, {1'b0, (i == 7), (exp_used_n >= 4), (exp_used_n < 4)}); end
        end
        n_wdata = n_next; #1;
        checks++; if (n_wr_ena !== 1'b0) begin failures++; $display("FAIL ninth_wr_ena got=%b exp=0", n_wr_ena); end
        tick();
        n_wrreq = 1'b0;
        checks++; if ({n_usedw, n_full} !== {4'd8, 1'b1}) begin failures++; $display("FAIL ninth_usedw got=%h exp=%h", {n_usedw, n_full}, {4'd8, 1'b1}); end
    endtask

    task automatic test_full_wr_rd();
        n_wrreq = 1'b1; n_rdreq = 1'b1; n_wdata = n_next; #1;
        checks++; if ({n_wr_ena, n_rd_ena, n_rd_addr} !== {2'b01, exp_ra_n}) begin failures++; $display("FAIL fullwr_ena got=%h exp=%h", {n_wr_ena, n_rd_ena, n_rd_addr}, {2'b01, exp_ra_n}); end
        exp_ra_n++; exp_used_n--;
        tick();
        n_wrreq = 1'b0; n_rdreq = 1'b0;
        exp_d = n_sb.pop_front();
        checks++; if (n_q !== exp_d) begin failures++; $display("FAIL fullwr_q got=%h exp=%h", n_q, exp_d); end
        checks++; if ({n_usedw, n_full, n_afull} !== {4'd7, 1'b0, 1'b1}) begin failures++; $display("FAIL fullwr_flags got=%h exp=%h", {n_usedw, n_full, n_afull}, {4'd7, 1'b0, 1'b1}); end
        for (int i = 0; i < 4; i++) begin
            n_rdreq = 1'b1; #1;
            checks++; if ({n_rd_ena, n_rd_addr} !== {1'b1, exp_ra_n}) begin failures++; $display("FAIL drain_rd got=%h exp=%h", {n_rd_ena, n_rd_addr}, {1'b1, exp_ra_n}); end
            exp_ra_n++; exp_used_n--;
            tick();
            exp_d = n_sb.pop_front();
            checks++; if ({n_q, n_usedw} !== {exp_d, exp_used_n}) begin failures++; $display("FAIL drain_q got=%h exp=%h", {n_q, n_usedw}, {exp_d, exp_used_n}); end
        end
        n_rdreq = 1'b0;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            n_wrreq = 1'b1; n_rdreq = 1'b1; n_wdata = n_next; #1;
            checks++; if ({n_wr_ena, n_rd_ena, n_wr_addr, n_rd_addr} !== {2'b11, exp_wa_n, exp_ra_n}) begin failures++; $display("FAIL wrap_addr got=%h exp=%h", {n_wr_ena, n_rd_ena, n_wr_addr, n_rd_addr}, {2'b11, exp_wa_n, exp_ra_n}); end
            n_sb.push_back(n_next); n_next++; exp_wa_n++; exp_ra_n++;
            tick();
            exp_d = n_sb.pop_front();
            checks++; if (n_q !== exp_d) begin failures++; $display("FAIL wrap_q got=%h exp=%h", n_q, exp_d); end
            checks++; if ({n_usedw, n_empty, n_full, n_afull, n_aempty} !== {4'd3, 4'b0001}) begin failures++; $display("FAIL wrap_flags got=%h exp=%h", {n_usedw, n_empty, n_full, n_afull, n_aempty}, {4'd3, 4'b0001}); end
        end
        n_wrreq = 1'b0; n_rdreq = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            n_wrreq = 1'b1; n_wdata = n_next; n_next++;
            tick();
        end
        checks++; if (n_usedw !== 4'd5) begin failures++; $display("FAIL mid_pre_usedw got=%0d exp=5", n_usedw); end
        srst = 1'b1; #1;
        checks++; if (n_wr_ena !== 1'b0) begin failures++; $display("FAIL mid_wr_forced got=%b exp=0", n_wr_ena); end
        tick();
        srst = 1'b0; n_wrreq = 1'b0; #1;
        checks++; if ({n_usedw, n_empty, n_full, n_afull, n_aempty, n_wr_addr, n_rd_addr} !== {4'd0, 4'b1001, 6'd0}) begin failures++; $display("FAIL mid_reset got=%h exp=%h", {n_usedw, n_empty, n_full, n_afull, n_aempty, n_wr_addr, n_rd_addr}, {4'd0, 4'b1001, 6'd0}); end
        n_sb.delete(); exp_wa_n = '0; exp_ra_n = '0; exp_used_n = '0;
        n_wrreq = 1'b1; n_wdata = n_next; #1;
        checks++; if ({n_wr_ena, n_wr_addr} !== {1'b1, 3'd0}) begin failures++; $display("FAIL mid_wr got=%h exp=%h", {n_wr_ena, n_wr_addr}, {1'b1, 3'd0}); end
        n_sb.push_back(n_next); n_next++;
        tick();
        n_wrreq = 1'b0;
        checks++; if ({n_usedw, n_empty} !== {4'd1, 1'b0}) begin failures++; $display("FAIL mid_after_wr got=%h exp=%h", {n_usedw, n_empty}, {4'd1, 1'b0}); end
        n_rdreq = 1'b1;
        tick();
        n_rdreq = 1'b0;
        exp_d = n_sb.pop_front();
        checks++; if ({n_q, n_usedw, n_empty} !== {exp_d, 4'd0, 1'b1}) begin failures++; $display("FAIL mid_rd got=%h exp=%h", {n_q, n_usedw, n_empty}, {exp_d, 4'd0, 1'b1}); end
    endtask

    task automatic test_sa_single();
        s_wrreq = 1'b1; s_wdata = s_next; #1;
        checks++; if ({s_wr_ena, s_wr_addr} !== {1'b1, exp_wa_s}) begin failures++; $display("FAIL sa_single_wr got=%h exp=%h", {s_wr_ena, s_wr_addr}, {1'b1, exp_wa_s}); end
        s_sb.push_back(s_next); s_next++; exp_wa_s++;
        tick();
        s_wrreq = 1'b0; #1;
        checks++; if ({s_empty, s_rd_ena, s_usedw, s_rd_addr} !== {2'b11, 4'd1, exp_ra_s}) begin failures++; $display("FAIL sa_fetch got=%h exp=%h", {s_empty, s_rd_ena, s_usedw, s_rd_addr}, {2'b11, 4'd1, exp_ra_s}); end
        exp_ra_s++;
        tick();
        checks++; if ({s_empty, s_rd_ena, s_q, s_rd_addr} !== {2'b00, s_sb[0], exp_ra_s}) begin failures++; $display("FAIL sa_valid got=%h exp=%h", {s_empty, s_rd_ena, s_q, s_rd_addr}, {2'b00, s_sb[0], exp_ra_s}); end
        s_rdreq = 1'b1; #1;
        checks++; if (s_rd_ena !== 1'b0) begin failures++; $display("FAIL sa_last_rd_ena got=%b exp=0", s_rd_ena); end
        void'(s_sb.pop_front());
        tick();
        checks++; if ({s_empty, s_usedw} !== {1'b1, 4'd0}) begin failures++; $display("FAIL sa_drained got=%h exp=%h", {s_empty, s_usedw}, {1'b1, 4'd0}); end
        #1;
        checks++; if (s_rd_ena !== 1'b0) begin failures++; $display("FAIL sa_rd_empty got=%b exp=0", s_rd_ena); end
        tick();
        s_rdreq = 1'b0;
        checks++; if (s_usedw !== 4'd0) begin failures++; $display("FAIL sa_underflow got=%0d exp=0", s_usedw); end
    endtask

    task automatic test_sa_full();
        for (int i = 0; i < 8; i++) begin
            s_wrreq = 1'b1; s_wdata = s_next; #1;
            checks++; if ({s_wr_ena, s_wr_addr} !== {1'b1, exp_wa_s}) begin failures++; $display("FAIL sa_fill_wr got=%h exp=%h", {s_wr_ena, s_wr_addr}, {1'b1, exp_wa_s}); end
            s_sb.push_back(s_next); s_next++; exp_wa_s++;
            tick();
        end
        s_wrreq = 1'b0;
        checks++; if ({s_full, s_empty, s_usedw, s_q} !== {2'b10, 4'd8, s_sb[0]}) begin failures++; $display("FAIL sa_full got=%h exp=%h", {s_full, s_empty, s_usedw, s_q}, {2'b10, 4'd8, s_sb[0]}); end
        s_wrreq = 1'b1; s_rdreq = 1'b1; s_wdata = s_next; #1;
        checks++; if ({s_wr_ena, s_rd_ena} !== 2'b01) begin failures++; $display("FAIL sa_fullwr_ena got=%b exp=01", {s_wr_ena, s_rd_ena}); end
        void'(s_sb.pop_front());
        tick();
        s_wrreq = 1'b0; s_rdreq = 1'b0;
        checks++; if ({s_usedw, s_full, s_afull, s_empty, s_q} !== {4'd7, 3'b010, s_sb[0]}) begin failures++; $display("FAIL sa_fullwr got=%h exp=%h", {s_usedw, s_full, s_afull, s_empty, s_q}, {4'd7, 3'b010, s_sb[0]}); end
        for (int k = 0; k < 7; k++) begin
            s_rdreq = 1'b1; #1;
            exp_d = s_sb.pop_front();
            checks++; if ({s_empty, s_q, s_rd_ena} !== {1'b0, exp_d, (k < 6)}) begin failures++; $display("FAIL sa_drain got=%h exp=%h", {s_empty, s_q, s_rd_ena}, {1'b0, exp_d, (k < 6)}); end
            tick();
        end
        s_rdreq = 1'b0;
        checks++; if ({s_empty, s_usedw} !== {1'b1, 4'd0} || s_sb.size() != 0) begin failures++; $display("FAIL sa_drain_end got=%h exp=%h", {s_empty, s_usedw}, {1'b1, 4'd0}); end
    endtask

    task automatic test_sa_refill();
        s_wrreq = 1'b1; s_wdata = s_next; s_sb.push_back(s_next); s_next++;
        tick();
        s_wrreq = 1'b0;
        tick();
        s_wrreq = 1'b1; s_rdreq = 1'b1; s_wdata = s_next; #1;
        exp_d = s_sb.pop_front();
        checks++; if ({s_wr_ena, s_rd_ena, s_q} !== {2'b10, exp_d}) begin failures++; $display("FAIL sa_refill_rw got=%h exp=%h", {s_wr_ena, s_rd_ena, s_q}, {2'b10, exp_d}); end
        s_sb.push_back(s_next); s_next++;
        tick();
        s_wrreq = 1'b0; s_rdreq = 1'b0; #1;
        checks++; if ({s_empty, s_rd_ena, s_usedw} !== {2'b11, 4'd1}) begin failures++; $display("FAIL sa_refill_fetch got=%h exp=%h", {s_empty, s_rd_ena, s_usedw}, {2'b11, 4'd1}); end
        tick();
        checks++; if ({s_empty, s_q} !== {1'b0, s_sb[0]}) begin failures++; $display("FAIL sa_refill_valid got=%h exp=%h", {s_empty, s_q}, {1'b0, s_sb[0]}); end
        s_rdreq = 1'b1; void'(s_sb.pop_front());
        tick();
        s_rdreq = 1'b0;
        checks++; if (s_empty !== 1'b1) begin failures++; $display("FAIL sa_refill_end got=%b exp=1", s_empty); end
    endtask

`ifdef B2_SCFIFO_ERR_FLAGS_EN
    task automatic test_err_flags();
        n_rdreq = 1'b1;
        tick();
        n_rdreq = 1'b0;
        checks++; if ({n_unf, n_ovf} !== 2'b10) begin failures++; $display("FAIL unf_set got=%b exp=10", {n_unf, n_ovf}); end
        for (int i = 0; i < 8; i++) begin
            n_wrreq = 1'b1; n_wdata = n_next; n_next++;
            tick();
        end
        checks++; if ({n_unf, n_ovf, n_full} !== 3'b101) begin failures++; $display("FAIL unf_hold got=%b exp=101", {n_unf, n_ovf, n_full}); end
        tick();
        n_wrreq = 1'b0;
        checks++; if ({n_unf, n_ovf} !== 2'b11) begin failures++; $display("FAIL ovf_set got=%b exp=11", {n_unf, n_ovf}); end
        srst = 1'b1;
        tick();
        srst = 1'b0;
        checks++; if ({n_unf, n_ovf} !== 2'b00) begin failures++; $display("FAIL err_clear got=%b exp=00", {n_unf, n_ovf}); end
    endtask
`endif

    initial begin
        srst = 1'b0;
        n_wrreq = 1'b0; n_rdreq = 1'b0; s_wrreq = 1'b0; s_rdreq = 1'b0;
        n_wdata = '0; s_wdata = '0;
        tick();
        test_reset();
        test_fill();
        test_full_wr_rd();
        test_wrap();
        test_reset_mid();
        test_sa_single();
        test_sa_full();
        test_sa_refill();
`ifdef B2_SCFIFO_ERR_FLAGS_EN
        test_err_flags();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/b2_scfifo_ctrl.md
# b2_scfifo_ctrl

Parametrised single-clock FIFO controller, next generation of the SCFIFO control FSM. Owns the write/read pointers and the fill counter, drives the write, read and output-register enables of an external dual-port RAM with a 1-cycle registered read, and generates empty/full/almost flags. Selects normal or show-ahead read mode at elaboration. Sits between the SCFIFO top level and its RAM.

## Interface
- AWIDTH, 8, address width; DEPTH = 2**AWIDTH words
- SHOWAHEAD, 0, 0 = normal mode (data valid on q the cycle after rdreq); 1 = show-ahead (head word present on q while !empty_o; rdreq acknowledges it)
- ALMOST_FULL_VALUE, 2**AWIDTH-4, almost_full_o threshold
- ALMOST_EMPTY_VALUE, 4, almost_empty_o threshold

- clk_i  in  1  clock
- srst_i  in  1  reset; one clock, synchronous, active-high
- wrreq_i  in  1  write request
- rdreq_i  in  1  read request / show-ahead acknowledge
- wr_ena_o  out  1  RAM write enable
- wr_addr_o  out  AWIDTH  RAM write address
- rd_ena_o  out  1  RAM read enable (loads RAM output register)
- rd_addr_o  out  AWIDTH  RAM read address
- empty_o  out  1  no word available to read
- full_o  out  1  DEPTH words stored
- almost_full_o  out  1  usedw_o >= ALMOST_FULL_VALUE
- almost_empty_o  out  1  usedw_o < ALMOST_EMPTY_VALUE
- usedw_o  out  AWIDTH+1  words stored, 0..DEPTH (includes word held on q in show-ahead)

## Operation
- wr_acc = wrreq_i & !full_o; rd_acc = rdreq_i & !empty_o. Requests against full/empty are ignored, never corrupt state.
- wr_ena_o = wr_acc (combinational, forced 0 during srst_i). wr_addr_o increments on each wr_acc, wraps DEPTH-1 -> 0.
- rd_addr_o increments on each rd_ena_o, wraps DEPTH-1 -> 0.
- usedw_o: +1 on wr_acc only, -1 on rd_acc only, unchanged on both/neither. Registered; no overflow past DEPTH, no underflow below 0.
- full_o, almost_full_o, almost_empty_o registered from next usedw_o value (aligned with usedw_o).
- Normal mode: rd_ena_o = rd_acc; empty_o = (usedw_o == 0).
- Show-ahead FSM (states EMPTY_ST, FETCH_ST, VALID_ST, FULL_ST):
  - EMPTY_ST: empty_o=1. wr_acc -> FETCH_ST.
  - FETCH_ST: empty_o=1, rd_ena_o=1 (head word into RAM output register) -> VALID_ST.
  - VALID_ST: empty_o=0. rd_acc with another unread word in RAM: rd_ena_o=1, stay. rd_acc with none and no wr_acc -> EMPTY_ST; rd_acc with none but wr_acc -> FETCH_ST. usedw reaching DEPTH -> FULL_ST.
  - FULL_ST: full_o=1, empty_o=0. rd_acc -> VALID_ST with rd_ena_o=1.
- Simultaneous wr+rd: when full, read accepted, write rejected; when empty, write accepted, read rejected; otherwise both, usedw_o unchanged.
- Reset mid-operation: contents discarded; next cycle all outputs at reset values.

## Timing
- Reset values: usedw_o=0, pointers=0, empty_o=1, full_o=0, almost_full_o=0, almost_empty_o=1 (ALMOST_EMPTY_VALUE>0), wr_ena_o=rd_ena_o=0, FSM=EMPTY_ST.
- Write into empty FIFO at edge N: normal mode empty_o=0 after edge N; show-ahead empty_o=0 after edge N+1 (RAM write, then fetch; no read-during-write on same address).
- Normal mode read: rdreq_i in cycle N -> data on RAM output after edge N.
- Show-ahead: rd_acc at edge N -> next word on q after edge N (prefetched) when usedw_o>=2.
- Full: full_o=1 the cycle after the DEPTH-th accepted write; deasserts the cycle after the first rd_acc.

## Configuration
- B2_SCFIFO_ERR_FLAGS_EN defined: extra outputs ovf_o and unf_o (1 bit each, reset 0). ovf_o sets sticky on wrreq_i while full_o; unf_o sets sticky on rdreq_i while empty_o; cleared only by srst_i.
- Not defined: ports absent; rejected requests silently dropped.

## Test plan
- AWIDTH=3, SHOWAHEAD=0: reset, 8 writes -> usedw_o 1..8, full_o=1 after 8th, almost_full_o=1 from usedw_o=4; 9th write -> wr_ena_o=0, usedw_o stays 8.
- AWIDTH=3, SHOWAHEAD=1: single write at edge N -> empty_o=1 through cycle N+1, 0 after edge N+1, rd_ena_o pulsed in FETCH_ST, usedw_o=1.
- Full FIFO, wrreq_i=rdreq_i=1 one cycle -> read accepted, write rejected, usedw_o=7, full_o=0, almost_full_o=1.
- 20 write/read cycles, usedw_o held at 3 -> wr_addr_o and rd_addr_o wrap 7->0, read order matches write order, flags stable.
- srst_i asserted with usedw_o=5 -> next cycle usedw_o=0, empty_o=1, pointers 0; next write behaves as from reset.
- B2_SCFIFO_ERR_FLAGS_EN: rdreq_i while empty -> unf_o=1, held until srst_i; wrreq_i while full -> ovf_o=1.
